// File: rtl/mxn_piso_unloader_pkg.sv
// Shared types and helpers for the MxN frame-to-word unloader.
package mxn_piso_unloader_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Word-index width: clog2(n), never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mxn_piso_unloader.sv
// Drains one parallel N-word frame onto an M-bit valid/ready stream, word 0 first,
// with zero-bubble back-to-back frames and full back-pressure.
module mxn_piso_unloader
    import mxn_piso_unloader_pkg::*;
#(
    parameter int unsigned M = 3,
    parameter int unsigned N = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [M*N-1:0]   in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [M-1:0]     out_data,
    output logic             out_last,
    output logic             busy
);

    localparam int unsigned W        = M * N;
    localparam int unsigned IDXW     = idx_width(N);
    localparam logic        ONE_WORD = (N == 1);

    state_t            state;
    logic [W-1:0]      sreg;
    logic [IDXW-1:0]   idx;
    logic [IDXW-1:0]   idx_nxt;
    logic              last_q;

    assign idx_nxt = idx + IDXW'(1);

    // A new frame may enter while idle, or on the very cycle the last word leaves.
    assign in_ready  = (state == ST_IDLE) || (last_q && out_ready);

    assign out_valid = (state == ST_SHIFT);
    assign busy      = (state == ST_SHIFT);
    assign out_data  = sreg[M-1:0];
    assign out_last  = last_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            sreg   <= '0;
            idx    <= '0;
            last_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        sreg   <= in_data;
                        idx    <= '0;
                        last_q <= ONE_WORD;
                        state  <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (out_ready) begin
                        if (last_q) begin
                            idx <= '0;
                            if (in_valid) begin
                                sreg   <= in_data;
                                last_q <= ONE_WORD;
                            end else begin
                                sreg   <= '0;
                                last_q <= 1'b0;
                                state  <= ST_IDLE;
                            end
                        end else begin
                            sreg   <= sreg >> M;
                            idx    <= idx_nxt;
                            last_q <= (idx_nxt == IDXW'(N - 1));
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
